// File: rtl/fp_unpack_pkg.sv
// Shared types and constants for the IEEE-754 unpack/normalise sequencer.
// fp_decode splits a left-aligned operand into sign, biased-removed exponent and significand.
package fp_unpack_pkg;

    typedef enum logic [1:0] {
        FMT_HALF     = 2'b00,
        FMT_SINGLE   = 2'b01,
        FMT_DOUBLE   = 2'b10,
        FMT_DOUBLE_X = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_NORM = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int EXP_W_H  = 5;
    localparam int EXP_W_S  = 8;
    localparam int EXP_W_D  = 11;
    localparam int FRAC_W_H = 10;
    localparam int FRAC_W_S = 23;
    localparam int FRAC_W_D = 52;
    localparam int BIAS_H   = 15;
    localparam int BIAS_S   = 127;
    localparam int BIAS_D   = 1023;

    localparam int SIG_W  = 53;
    localparam int EXPB_W = 12;
    localparam int LZC_W  = 6;

    typedef struct packed {
        logic                     sign;
        logic signed [EXPB_W-1:0] exp;
        logic [SIG_W-1:0]         sig;
        logic                     e_z;
        logic                     e_inf;
        logic                     frac_nz;
        logic                     frac_msb;
    } dec_t;

    function automatic dec_t fp_decode(input logic [63:0] fp, input fmt_e fmt);
        dec_t        d;
        logic [10:0] field;
        logic [10:0] ones;
        logic [10:0] bias;
        logic [10:0] field_adj;
        logic [51:0] frac;
        case (fmt)
            FMT_HALF: begin
                field = 11'(fp[62 -: EXP_W_H]);
                ones  = 11'((1 << EXP_W_H) - 1);
                bias  = 11'(BIAS_H);
                frac  = {fp[62-EXP_W_H -: FRAC_W_H], {(FRAC_W_D-FRAC_W_H){1'b0}}};
            end
            FMT_SINGLE: begin
                field = 11'(fp[62 -: EXP_W_S]);
                ones  = 11'((1 << EXP_W_S) - 1);
                bias  = 11'(BIAS_S);
                frac  = {fp[62-EXP_W_S -: FRAC_W_S], {(FRAC_W_D-FRAC_W_S){1'b0}}};
            end
            default: begin
                field = fp[62 -: EXP_W_D];
                ones  = 11'((1 << EXP_W_D) - 1);
                bias  = 11'(BIAS_D);
                frac  = fp[62-EXP_W_D -: FRAC_W_D];
            end
        endcase
        d.sign     = fp[63];
        d.e_z      = (field == 11'd0);
        d.e_inf    = (field == ones);
        // Denormals share the minimum normal exponent (field treated as 1).
        field_adj  = d.e_z ? 11'd1 : field;
        d.exp      = $signed({1'b0, field_adj}) - $signed({1'b0, bias});
        d.sig      = {~d.e_z, frac};
        d.frac_nz  = |frac;
        d.frac_msb = frac[51];
        return d;
    endfunction

endpackage

// File: rtl/lzc53.sv
// Leading-zero count of a 53-bit significand; an all-zero input reports 53.
module lzc53
    import fp_unpack_pkg::*;
(
    input  logic [SIG_W-1:0] i_val,
    output logic [LZC_W-1:0] o_cnt
);

    always_comb begin
        o_cnt = LZC_W'(SIG_W);
        // Ascending scan: the highest set bit is the last to assign.
        for (int i = 0; i < SIG_W; i++) begin
            if (i_val[i]) o_cnt = LZC_W'(SIG_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_unpack_seq.sv
// Unpacks a half/single/double operand into sign, unbiased exponent and 53-bit significand,
// normalising denormals over several cycles with a bounded shift per cycle.
//
// state | meaning
// IDLE  | no result held, ready for an operand
// NORM  | denormal significand being shifted toward f[52]
// DONE  | result valid; may hand off and take the next operand in the same cycle
module fp_unpack_seq
    import fp_unpack_pkg::*;
#(
    parameter int EOUT      = 13,
    parameter int NORM_STEP = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            fp,
    input  logic [1:0]             fmt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   s,
    output logic signed [EOUT-1:0] e,
    output logic [SIG_W-1:0]       f,
    output logic                   e_z,
    output logic                   e_inf,
    output logic                   is_zero,
    output logic                   is_denorm,
    output logic                   is_inf,
    output logic                   is_nan,
    output logic                   is_snan
);

    localparam logic [LZC_W-1:0] STEP = LZC_W'(NORM_STEP);

    state_e                 r_state;
    state_e                 w_next;
    logic                   r_s;
    logic signed [EOUT-1:0] r_e;
    logic [SIG_W-1:0]       r_f;
    logic                   r_e_z;
    logic                   r_e_inf;
    logic                   r_is_zero;
    logic                   r_is_denorm;
    logic                   r_is_inf;
    logic                   r_is_nan;
    logic                   r_is_snan;

    dec_t                   w_dec;
    logic                   w_accept;
    logic                   w_dec_denorm;
    logic [LZC_W-1:0]       w_lz;
    logic                   w_big;
    logic [LZC_W-1:0]       w_shamt;
    logic signed [EOUT-1:0] w_shamt_e;
    logic signed [EOUT-1:0] w_base_e;

    assign w_dec        = fp_decode(fp, fmt_e'(fmt));
    assign w_dec_denorm = w_dec.e_z & w_dec.frac_nz;
    assign w_base_e     = {{(EOUT-EXPB_W){w_dec.exp[EXPB_W-1]}}, w_dec.exp};

    assign in_ready = ~rst & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
    assign w_accept = in_valid & in_ready;

    lzc53 u_lzc (
        .i_val (r_f),
        .o_cnt (w_lz)
    );

    assign w_big     = (w_lz >= STEP);
    assign w_shamt   = w_big ? STEP : w_lz;
    assign w_shamt_e = {{(EOUT-LZC_W){1'b0}}, w_shamt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = w_dec_denorm ? ST_NORM : ST_DONE;
            end
            ST_NORM: begin
                if (!w_big) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept)       w_next = w_dec_denorm ? ST_NORM : ST_DONE;
                else if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s         <= 1'b0;
            r_e         <= '0;
            r_f         <= '0;
            r_e_z       <= 1'b0;
            r_e_inf     <= 1'b0;
            r_is_zero   <= 1'b0;
            r_is_denorm <= 1'b0;
            r_is_inf    <= 1'b0;
            r_is_nan    <= 1'b0;
            r_is_snan   <= 1'b0;
        end else if (w_accept) begin
            r_s         <= w_dec.sign;
            r_e         <= w_base_e;
            r_f         <= w_dec.sig;
            r_e_z       <= w_dec.e_z;
            r_e_inf     <= w_dec.e_inf;
            r_is_zero   <= w_dec.e_z & ~w_dec.frac_nz;
            r_is_denorm <= w_dec_denorm;
            r_is_inf    <= w_dec.e_inf & ~w_dec.frac_nz;
            r_is_nan    <= w_dec.e_inf & w_dec.frac_nz;
            r_is_snan   <= w_dec.e_inf & w_dec.frac_nz & ~w_dec.frac_msb;
        end else if (r_state == ST_NORM) begin
            r_f <= r_f << w_shamt;
            r_e <= r_e - w_shamt_e;
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign s         = r_s;
    assign e         = r_e;
    assign f         = r_f;
    assign e_z       = r_e_z;
    assign e_inf     = r_e_inf;
    assign is_zero   = r_is_zero;
    assign is_denorm = r_is_denorm;
    assign is_inf    = r_is_inf;
    assign is_nan    = r_is_nan;
    assign is_snan   = r_is_snan;

endmodule

// File: tb/tb_fp_unpack_seq.sv
// Scoreboard bench for fp_unpack_seq: a reference decoder predicts every result and its latency.
module tb_fp_unpack_seq;

    localparam int NSTEP = 8;
    localparam logic [52:0] HID = 53'h10000000000000;

    typedef struct {
        logic        s;
        logic [12:0] e;
        logic [52:0] f;
        logic [6:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        fp;
    logic [1:0]         fmt;
    logic               out_valid;
    logic               out_ready;
    logic               s;
    logic signed [12:0] e;
    logic [52:0]        f;
    logic               e_z, e_inf, is_zero, is_denorm, is_inf, is_nan, is_snan;
    logic [6:0]         flags;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   fresh = 1'b1;
    bit   sending = 1'b0;
    exp_t sb[$];
    exp_t h;

    assign flags = {e_z, e_inf, is_zero, is_denorm, is_inf, is_nan, is_snan};

    fp_unpack_seq #(.EOUT(13), .NORM_STEP(NSTEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fp(fp), .fmt(fmt),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .e(e), .f(f),
        .e_z(e_z), .e_inf(e_inf), .is_zero(is_zero), .is_denorm(is_denorm),
        .is_inf(is_inf), .is_nan(is_nan), .is_snan(is_snan)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [63:0] v, input logic [1:0] m);
        exp_t r;
        int ew, fw, bias, expo, l0;
        longint unsigned field, frac, fa, f64, emask;
        bit ez, einf;
        case (m)
            2'b00:   begin ew = 5;  fw = 10; bias = 15;   end
            2'b01:   begin ew = 8;  fw = 23; bias = 127;  end
            default: begin ew = 11; fw = 52; bias = 1023; end
        endcase
        emask = (64'd1 << ew) - 64'd1;
        field = (v >> (63 - ew)) & emask;
        frac  = (v >> (63 - ew - fw)) & ((64'd1 << fw) - 64'd1);
        fa    = frac << (52 - fw);
        ez    = (field == 0);
        einf  = (field == emask);
        expo  = (ez ? 1 : int'(field)) - bias;
        f64   = ez ? fa : (fa | (64'd1 << 52));
        r.lat = 1;
        if (ez && frac != 0) begin
            l0 = 0;
            while (f64[52] == 1'b0) begin
                f64 = f64 << 1;
                l0++;
            end
            expo  = expo - l0;
            r.lat = l0 / NSTEP + 2;
        end
        r.s     = v[63];
        r.e     = 13'(expo);
        r.f     = f64[52:0];
        r.flags = {ez, einf, ez && frac == 0, ez && frac != 0, einf && frac == 0,
                   einf && frac != 0, einf && frac != 0 && fa[51] == 1'b0};
        r.acc   = 0;
        return r;
    endfunction

    // Result monitor: latency on first appearance, full compare on handshake.
    always @(negedge clk) begin
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: out_valid=1 with empty scoreboard at cycle %0d", cyc);
            end else begin
                h = sb[0];
                if (fresh) begin
                    checks++;
                    if (cyc - h.acc !== h.lat - 1) begin
                        errors++;
                        $display("FAIL latency: got %0d required %0d", cyc - h.acc + 1, h.lat);
                    end
                    fresh = 1'b0;
                end
                if (out_ready) begin
                    checks++;
                    if ({s, e, f, flags} !== {h.s, h.e, h.f, h.flags}) begin
                        errors++;
                        $display("FAIL result: got s=%0b e=%0d f=%h flags=%b required s=%0b e=%0d f=%h flags=%b",
                                 s, e, f, flags, h.s, $signed(h.e), h.f, h.flags);
                    end
                    void'(sb.pop_front());
                    fresh = 1'b1;
                end
            end
        end else begin
            fresh = 1'b1;
        end
    end

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic send(input logic [63:0] v, input logic [1:0] m);
        exp_t x;
        int   n;
        x = model(v, m);
        n = 0;
        in_valid = 1'b1; fp = v; fmt = m;
        #1;
        while (!in_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        x.acc = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!out_valid && k < 60) begin
            @(negedge clk); #1; k++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, s, e, f, flags} !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b s=%0b e=%0d f=%h flags=%b required all 0",
                     in_ready, out_valid, s, e, f, flags);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %0b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_double_one;
        int k;
        send(64'h3FF0000000000000, 2'b10); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (k !== 1 || s !== 1'b0 || e !== 13'sd0 || f !== HID || flags !== 7'b0) begin
            errors++;
            $display("FAIL double_one: lat=%0d s=%0b e=%0d f=%h flags=%b required 1 0 0 %h 0", k, s, e, f, flags, HID);
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        int k;
        send(64'h3F800000_00000000, 2'b01); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (k !== 1 || e !== 13'sd0 || f !== HID) begin
            errors++; $display("FAIL single_one: lat=%0d e=%0d f=%h required 1 0 %h", k, e, f, HID);
        end
        @(negedge clk);
        send(64'hC0000000_00000000, 2'b01); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (s !== 1'b1 || e !== 13'sd1 || f !== HID) begin
            errors++; $display("FAIL single_m2: s=%0b e=%0d f=%h required 1 1 %h", s, e, f, HID);
        end
        @(negedge clk);
    endtask

    task automatic test_denorm;
        logic [63:0] tv[5] = '{64'h0000000000000001, 64'h0000100000000000, 64'h0008000000000000,
                               64'h0001000000000000, 64'h00000001_00000000};
        logic [1:0]  tm[5] = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
        int          tl[5] = '{8, 3, 2, 3, 4};
        int          te[5] = '{-1074, -1030, -1023, -24, -149};
        int k;
        for (int i = 0; i < 5; i++) begin
            send(tv[i], tm[i]); in_valid = 1'b0; #1;
            wait_valid(k);
            checks++;
            if (k !== tl[i] || e !== 13'(te[i]) || f !== HID || is_denorm !== 1'b1 || e_z !== 1'b1) begin
                errors++;
                $display("FAIL denorm_%0d: lat=%0d e=%0d f=%h is_denorm=%0b required %0d %0d %h 1",
                         i, k, e, f, is_denorm, tl[i], te[i], HID);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_special;
        int k;
        send(64'h7F800000_00000000, 2'b01); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (is_inf !== 1'b1 || e_inf !== 1'b1 || is_nan !== 1'b0 || f !== HID || e !== 13'sd128) begin
            errors++; $display("FAIL single_inf: is_inf=%0b e_inf=%0b is_nan=%0b f=%h e=%0d required 1 1 0 %h 128",
                               is_inf, e_inf, is_nan, f, e, HID);
        end
        @(negedge clk);
        send(64'h7FA00000_00000000, 2'b01); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (is_nan !== 1'b1 || is_snan !== 1'b1 || is_inf !== 1'b0) begin
            errors++; $display("FAIL single_snan: is_nan=%0b is_snan=%0b is_inf=%0b required 1 1 0", is_nan, is_snan, is_inf);
        end
        @(negedge clk);
        send(64'h7E00000000000000, 2'b00); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (is_nan !== 1'b1 || is_snan !== 1'b0) begin
            errors++; $display("FAIL half_qnan: is_nan=%0b is_snan=%0b required 1 0", is_nan, is_snan);
        end
        @(negedge clk);
        send(64'h8000000000000000, 2'b10); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (k !== 1 || is_zero !== 1'b1 || s !== 1'b1 || f !== 53'd0 || e !== 13'(-1022)) begin
            errors++; $display("FAIL neg_zero: lat=%0d is_zero=%0b s=%0b f=%h e=%0d required 1 1 1 0 -1022",
                               k, is_zero, s, f, e);
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        int k;
        logic [73:0] snap;
        out_ready = 1'b0;
        send(64'h4000000000000000, 2'b10); in_valid = 1'b0; #1;
        wait_valid(k);
        snap = {s, e, f, flags};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fp = {$urandom, $urandom}; fmt = 2'($urandom_range(0, 3));
            #1;
            checks++;
            if ({s, e, f, flags} !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d: outputs=%h in_ready=%0b out_valid=%0b required %h 0 1",
                         i, {s, e, f, flags}, in_ready, out_valid, snap);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [63:0] tv[6] = '{64'h3FF0000000000000, 64'h4008000000000000, 64'h3C00000000000000,
                               64'hC2280000_00000000, 64'h7BFF000000000000, 64'h0010000000000000};
        logic [1:0]  tm[6] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 6; i++) send(tv[i], tm[i]);
        in_valid = 1'b0;
        checks++;
        if (cyc - c0 !== 6) begin
            errors++; $display("FAIL back_to_back_cycles: got %0d required 6", cyc - c0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_norm;
        int k;
        send(64'h0000000000000001, 2'b10); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || e !== 13'sd0 || f !== 53'd0 || is_denorm !== 1'b0) begin
            errors++; $display("FAIL rst_mid_norm: out_valid=%0b in_ready=%0b e=%0d f=%h is_denorm=%0b required all 0",
                               out_valid, in_ready, e, f, is_denorm);
        end
        sb.delete();
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        send(64'hBFF8000000000000, 2'b10); in_valid = 1'b0; #1;
        wait_valid(k);
        checks++;
        if (k !== 1 || s !== 1'b1 || e !== 13'sd0 || f !== 53'h18000000000000) begin
            errors++; $display("FAIL after_reset: lat=%0d s=%0b e=%0d f=%h required 1 1 0 18000000000000", k, s, e, f);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [63:0] v;
        sending = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    v = {$urandom, $urandom};
                    if (i % 4 == 0) v[62:48] = '0;
                    send(v, 2'($urandom_range(0, 3)));
                end
                in_valid = 1'b0;
                sending = 1'b0;
            end
            begin
                while (sending) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
    endtask

    task automatic test_drain;
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fp = '0; fmt = '0;
        test_reset;
        test_double_one;
        test_single;
        test_denorm;
        test_special;
        test_stall;
        test_back_to_back;
        test_reset_mid_norm;
        test_random;
        test_drain;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_unpack_seq.md
FP_UNPACK_SEQ -- requirements
Module: fp_unpack_seq

Interface
REQ-001 SHALL have parameter EOUT, default 13, meaning signed unbiased exponent output width (min 13).
REQ-002 SHALL have parameter NORM_STEP, default 8, meaning max left-shift per normalisation cycle (1..16).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand valid.
REQ-006 SHALL have port in_ready  output  1  operand accepted when in_valid & in_ready.
REQ-007 SHALL have port fp  input  64  operand, left-aligned: double fp[63:0], single fp[63:32], half fp[63:48].
REQ-008 SHALL have port fmt  input  2  format: 00 half, 01 single, 10 double, 11 treated as double.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-011 SHALL have port s  output  1  sign.
REQ-012 SHALL have port e  output  EOUT  signed two's-complement unbiased exponent, post-normalisation.
REQ-013 SHALL have port f  output  53  significand, hidden bit at f[52], fraction left-aligned, zero-padded.
REQ-014 SHALL have ports e_z, e_inf, is_zero, is_denorm, is_inf, is_nan, is_snan  output  1 each  classification flags.

Function
REQ-015 SHALL capture fp and fmt on accept; later input changes SHALL not affect the result.
REQ-016 SHALL set e_z = exponent field all zeros, e_inf = exponent field all ones, per fmt widths (5/8/11).
REQ-017 SHALL compute base exponent = field - bias (15/127/1023), field forced to 1 when e_z, sign-extended to EOUT.
REQ-018 SHALL set f[52] = ~e_z, below it the fraction field left-aligned.
REQ-019 SHALL classify: is_zero = e_z & frac==0; is_denorm = e_z & frac!=0; is_inf = e_inf & frac==0; is_nan = e_inf & frac!=0; is_snan = is_nan & frac MSB==0.
REQ-020 SHALL use FSM states IDLE, NORM, DONE.
REQ-021 IDLE: on accept go to NORM if is_denorm, else DONE.
REQ-022 NORM: each cycle, let L = leading zeros of f; if L >= NORM_STEP shift f left NORM_STEP and subtract NORM_STEP from e, stay; else shift left L, subtract L, go to DONE.
REQ-023 Denormal latency SHALL be floor(L0/NORM_STEP)+2 cycles accept-to-out_valid, L0 = initial leading zeros; all other operands 1 cycle.
REQ-024 DONE: out_valid=1; on out_ready go to IDLE, or directly accept the next operand.
REQ-025 in_ready SHALL be (state==IDLE) | (state==DONE & out_ready), giving throughput of one non-denormal per cycle.
REQ-026 While out_valid & ~out_ready all outputs SHALL hold stable.
REQ-027 Zero, inf, NaN SHALL bypass NORM; f and e hold REQ-017/018 values unmodified.
REQ-028 e arithmetic SHALL not overflow for EOUT>=13 (min -1074).

Reset
REQ-029 rst SHALL asynchronously force state IDLE, out_valid 0, s 0, e 0, f 0, all flags 0, including mid-NORM.
REQ-030 in_ready SHALL be 0 while rst is high and 1 the first cycle after release.

Structure
REQ-031 Package fp_unpack_pkg SHALL hold fmt enum, FSM state enum, per-format exponent width, fraction width and bias constants.
REQ-032 Leading-zero count over 53 bits SHALL be sub-module lzc53.

Verification
REQ-033 double fp=0x3FF0000000000000 fmt=10 -> next cycle out_valid, s=0, e=0, f=1<<52, all flags 0.
REQ-034 single fp=0x3F800000_00000000 fmt=01 -> 1 cycle: e=0, f=1<<52; fp=0xC0000000_00000000 -> s=1, e=1.
REQ-035 double fp=0x0000000000000001, NORM_STEP=8 -> out_valid 8 cycles after accept, e=-1074, f=1<<52, is_denorm=1.
REQ-036 single fp=0x7F800000_00000000 -> is_inf=1, e_inf=1; fp=0x7FA00000_00000000 -> is_nan=1, is_snan=1.
REQ-037 out_ready low 3 cycles with out_valid -> s/e/f/flags stable, in_ready=0; back-to-back normals with out_ready=1 -> one result per cycle.
REQ-038 rst pulsed during NORM -> out_valid=0 immediately, IDLE, in_ready=1 first cycle after release.
